alu_slice_shift_unit: RTL and testbench
=======================================

Name: alu_slice_shift_unit

Overview:
- Registered compute unit combining three functions:
  - a 1-bit ALU bit-slice (AND, OR, XOR, ADD/SUB, SLT pass-through, 1-bit MULT), with carry in/out for ripple chaining;
  - a 16-bit logical left shifter;
  - a 16-bit logical right shifter.
- Used as the per-bit building block and shift datapath of the processor ALU.
- All outputs are registered on one clock.

Parameters:
- WIDTH, 16, shifter data width.
- SHW, 4, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- en  input  1  register-update enable
- a  input  1  operand A bit
- b  input  1  operand B bit
- cin  input  1  carry in
- ainvert  input  1  invert A before use
- bnegate  input  1  invert B before use (SUB/SLT: drive with cin=1)
- less  input  1  SLT input from the MSB slice's set output
- op  input  3  operation select
- number  input  WIDTH  shifter operand
- range  input  SHW  shift amount, 0..WIDTH-1
- result  output  1  registered ALU result bit
- cout  output  1  registered carry out
- set  output  1  registered raw adder sum, for SLT chaining
- rshifted  output  WIDTH  registered number >> range
- lshifted  output  WIDTH  registered number << range

Behaviour:
- Reset: while reset=1, every output is 0, independent of clk and en. Reset may assert at any time; a pending update is discarded.
- Update rule: on each rising clk with reset=0 and en=1, all outputs load their next values. With en=0 they hold. Latency is exactly 1 cycle; there is no handshake.
- Operand conditioning:
  - ax = a XOR ainvert
  - bx = b XOR bnegate
  - sum = ax XOR bx XOR cin
  - carry = majority(ax, bx, cin)
- op decode (result / cout):
  - 000 AND: ax&bx / 0
  - 001 SHL: 0 / 0
  - 010 OR: ax|bx / 0
  - 011 XOR: ax^bx / 0
  - 100 ADD/SUB: sum / carry
  - 101 SLT: less / carry
  - 110 SHR: 0 / 0
  - 111 MULT: ax&bx / 0
- set: loads sum on every update, regardless of op.
- Shifters: rshifted and lshifted update on every enabled cycle regardless of op.
  - Both are logical shifts with zero fill.
  - Shift amount is range, 0..WIDTH-1.
  - range=0 passes number unchanged.
  - Bits shifted out are discarded.
- No X propagation from the shifters into result/cout. The ALU path does not depend on number or range.

Test Plan:
- Reset and hold:
  - Assert reset mid-run with outputs nonzero → all outputs 0 immediately.
  - Release reset with en=0 → outputs stay 0.
- AND/OR/XOR/MULT, with cin=0, ainvert=0, bnegate=0:
  - a=1, b=1: AND → result=1, cout=0.
  - a=1, b=0: OR → result=1.
  - a=1, b=1: XOR → result=0.
  - a=1, b=1: MULT → result=1.
  - In all four cases cout=0.
  - Each result appears one clock after the inputs.
- ADD, op=100:
  - a=1, b=1, cin=0 → result=0, cout=1.
  - a=1, b=1, cin=1 → result=1, cout=1.
  - a=1, b=0, cin=0 → result=1, cout=0.
- SUB and SLT, bnegate=1, cin=1:
  - a=1, b=1, op=100 → result=0, cout=1.
  - a=0, b=1, op=100 → result=1, cout=0.
  - op=101 with less=1 → result=1, set equals the sum bit.
- Shifters, range=1:
  - number=3 → rshifted=1, lshifted=6.
  - number=4 → rshifted=2, lshifted=8.
  - number=5 → rshifted=2, lshifted=10.
- Shift boundaries:
  - number=0x8001, range=15 → rshifted=0x0001, lshifted=0x8000.
  - range=0 → both outputs equal number.
  - en=0 while number changes → shift outputs hold.

Source files
------------

// File: rtl/alu_slice_shift_unit.sv
// ---------------------------------------------------------------------------
// alu_slice_shift_unit
//
// Purpose:
//   Registered compute block that pairs one bit-slice of the processor ALU
//   with the 16-bit logical shift datapath. The ALU slice is meant to be
//   replicated and rippled through cin/cout. The MSB slice's 'set' output
//   feeds back into the 'less' input of slice 0 to implement SLT.
//   The shifters update every enabled cycle, whatever 'op' says.
//   Everything visible at the ports comes from a register, so results
//   appear exactly one enabled clock after the inputs.
//
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous active-high reset, clears all outputs
//   en        in   1      register-update enable (outputs hold when low)
//   a, b      in   1      operand bits
//   cin       in   1      carry in from the previous slice
//   ainvert   in   1      invert a before use
//   bnegate   in   1      invert b before use (SUB/SLT, with cin=1)
//   less      in   1      SLT input from the MSB slice's set output
//   op        in   3      operation select
//   number    in   WIDTH  shifter operand
//   range     in   SHW    shift amount, 0..WIDTH-1
//   result    out  1      registered ALU result bit
//   cout      out  1      registered carry out
//   set       out  1      registered raw adder sum (SLT chaining)
//   rshifted  out  WIDTH  registered number >> range
//   lshifted  out  WIDTH  registered number << range
// ---------------------------------------------------------------------------
module alu_slice_shift_unit #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    input  logic             ainvert,
    input  logic             bnegate,
    input  logic             less,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] number,
    input  logic [SHW-1:0]   range,
    output logic             result,
    output logic             cout,
    output logic             set,
    output logic [WIDTH-1:0] rshifted,
    output logic [WIDTH-1:0] lshifted
);

    // Operation codes shared with the ALU control decoder. SHL and SHR
    // produce no slice result: their data comes from the shifter outputs.
    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_SHL  = 3'b001,
        OP_OR   = 3'b010,
        OP_XOR  = 3'b011,
        OP_ADD  = 3'b100,
        OP_SLT  = 3'b101,
        OP_SHR  = 3'b110,
        OP_MULT = 3'b111
    } alu_op_e;

    // Conditioned operands and full-adder terms. Subtraction is formed as
    // a + ~b + 1, so the adder itself never needs to know about SUB.
    logic ax;
    logic bx;
    logic sum;
    logic carry;

    assign ax    = a ^ ainvert;
    assign bx    = b ^ bnegate;
    assign sum   = ax ^ bx ^ cin;
    assign carry = (ax & bx) | (ax & cin) | (bx & cin);

    // Next values for the slice outputs. Only the arithmetic operations
    // (ADD/SUB and SLT) drive a carry out, so a ripple chain running a
    // logic op never shows a stale carry. MULT is the single-bit partial
    // product, which is an AND of the conditioned operands.
    logic result_next;
    logic cout_next;

    always_comb begin
        result_next = 1'b0;
        cout_next   = 1'b0;
        case (op)
            OP_AND: begin
                result_next = ax & bx;
            end
            OP_SHL: begin
                result_next = 1'b0;
            end
            OP_OR: begin
                result_next = ax | bx;
            end
            OP_XOR: begin
                result_next = ax ^ bx;
            end
            OP_ADD: begin
                result_next = sum;
                cout_next   = carry;
            end
            OP_SLT: begin
                result_next = less;
                cout_next   = carry;
            end
            OP_SHR: begin
                result_next = 1'b0;
            end
            OP_MULT: begin
                result_next = ax & bx;
            end
            default: begin
                result_next = 1'b0;
                cout_next   = 1'b0;
            end
        endcase
    end

    // Logarithmic barrel shifters. Stage k shifts by 2**k when bit k of
    // range is set. Each constant shift zero-fills, so bits pushed off
    // either end are simply lost. Stage 0 is the unshifted operand, which
    // makes range=0 a straight pass-through.
    logic [WIDTH-1:0] rstage [0:SHW];
    logic [WIDTH-1:0] lstage [0:SHW];

    assign rstage[0] = number;
    assign lstage[0] = number;

    for (genvar k = 0; k < SHW; k++) begin : g_shift_stage
        localparam int STEP = 1 << k;

        assign rstage[k+1] = range[k] ? (rstage[k] >> STEP) : rstage[k];
        assign lstage[k+1] = range[k] ? (lstage[k] << STEP) : lstage[k];
    end

    // Output register bank. Reset is asynchronous, so asserting it
    // mid-cycle clears the outputs at once and throws away whatever was
    // about to load. When en is low every output holds. 'set' always
    // captures the raw sum so the MSB slice can feed SLT whatever the op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result   <= 1'b0;
            cout     <= 1'b0;
            set      <= 1'b0;
            rshifted <= '0;
            lshifted <= '0;
        end else if (en) begin
            result   <= result_next;
            cout     <= cout_next;
            set      <= sum;
            rshifted <= rstage[SHW];
            lshifted <= lstage[SHW];
        end
    end

endmodule

// File: tb/tb_alu_slice_shift_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_slice_shift_unit
//
// Purpose:
//   Self-checking bench for alu_slice_shift_unit. A table of directed
//   vectors with hand-computed expected outputs drives the ALU ops and the
//   shifters. Hand-written sequences then cover reset, enable-hold and
//   one-cycle latency.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_alu_slice_shift_unit;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    logic             clk;
    logic             reset;
    logic             en;
    logic             a;
    logic             b;
    logic             cin;
    logic             ainvert;
    logic             bnegate;
    logic             less;
    logic [2:0]       op;
    logic [WIDTH-1:0] number;
    logic [SHW-1:0]   range;
    logic             result;
    logic             cout;
    logic             set;
    logic [WIDTH-1:0] rshifted;
    logic [WIDTH-1:0] lshifted;

    int n_checks;
    int n_fails;

    alu_slice_shift_unit #(
        .WIDTH(WIDTH),
        .SHW  (SHW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .ainvert (ainvert),
        .bnegate (bnegate),
        .less    (less),
        .op      (op),
        .number  (number),
        .range   (range),
        .result  (result),
        .cout    (cout),
        .set     (set),
        .rshifted(rshifted),
        .lshifted(lshifted)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One directed vector: inputs followed by the values expected one
    // enabled clock later.
    typedef struct {
        string            name;
        logic             a;
        logic             b;
        logic             cin;
        logic             ainvert;
        logic             bnegate;
        logic             less;
        logic [2:0]       op;
        logic [WIDTH-1:0] number;
        logic [SHW-1:0]   range;
        logic             exp_result;
        logic             exp_cout;
        logic             exp_set;
        logic [WIDTH-1:0] exp_r;
        logic [WIDTH-1:0] exp_l;
    } vec_t;

    vec_t vecs[$];

    // Queue up a vector for the table.
    task automatic addVec(input string name,
                          input logic va, input logic vb, input logic vcin,
                          input logic vainv, input logic vbneg, input logic vless,
                          input logic [2:0] vop,
                          input logic [WIDTH-1:0] vnum, input logic [SHW-1:0] vrange,
                          input logic eres, input logic ecout, input logic eset,
                          input logic [WIDTH-1:0] er, input logic [WIDTH-1:0] el);
        vec_t v;
        v.name = name;
        v.a = va;
        v.b = vb;
        v.cin = vcin;
        v.ainvert = vainv;
        v.bnegate = vbneg;
        v.less = vless;
        v.op = vop;
        v.number = vnum;
        v.range = vrange;
        v.exp_result = eres;
        v.exp_cout = ecout;
        v.exp_set = eset;
        v.exp_r = er;
        v.exp_l = el;
        vecs.push_back(v);
    endtask

    // Drive a vector's inputs on the falling edge, away from the active edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        a       = v.a;
        b       = v.b;
        cin     = v.cin;
        ainvert = v.ainvert;
        bnegate = v.bnegate;
        less    = v.less;
        op      = v.op;
        number  = v.number;
        range   = v.range;
    endtask

    // One comparison: counts it and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name,
                               input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    // Compare every output against an expected set.
    task automatic checkAll(input string name,
                            input logic eres, input logic ecout, input logic eset,
                            input logic [WIDTH-1:0] er, input logic [WIDTH-1:0] el);
        checkOutput({name, ".result"},   {15'd0, result}, {15'd0, eres});
        checkOutput({name, ".cout"},     {15'd0, cout},   {15'd0, ecout});
        checkOutput({name, ".set"},      {15'd0, set},    {15'd0, eset});
        checkOutput({name, ".rshifted"}, rshifted, er);
        checkOutput({name, ".lshifted"}, lshifted, el);
    endtask

    // Main sequence: reset, table vectors, then the multi-cycle corner cases.
    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b1;
        en       = 1'b0;
        a        = 1'b0;
        b        = 1'b0;
        cin      = 1'b0;
        ainvert  = 1'b0;
        bnegate  = 1'b0;
        less     = 1'b0;
        op       = 3'b000;
        number   = '0;
        range    = '0;

        //     name        a  b  ci ai bn ls op      number    rng    res co set rshift    lshift
        addVec("and11",   1, 1, 0, 0, 0, 0, 3'b000, 16'h0003, 4'd1,  1, 0, 0, 16'h0001, 16'h0006);
        addVec("or10",    1, 0, 0, 0, 0, 0, 3'b010, 16'h0004, 4'd1,  1, 0, 1, 16'h0002, 16'h0008);
        addVec("xor11",   1, 1, 0, 0, 0, 0, 3'b011, 16'h0005, 4'd1,  0, 0, 0, 16'h0002, 16'h000A);
        addVec("mult11",  1, 1, 0, 0, 0, 0, 3'b111, 16'h8001, 4'd15, 1, 0, 0, 16'h0001, 16'h8000);
        addVec("add110",  1, 1, 0, 0, 0, 0, 3'b100, 16'h1234, 4'd0,  0, 1, 0, 16'h1234, 16'h1234);
        addVec("add111",  1, 1, 1, 0, 0, 0, 3'b100, 16'hFFFF, 4'd4,  1, 1, 1, 16'h0FFF, 16'hFFF0);
        addVec("add100",  1, 0, 0, 0, 0, 0, 3'b100, 16'hA5A5, 4'd8,  1, 0, 1, 16'h00A5, 16'hA500);
        addVec("sub11",   1, 1, 1, 0, 1, 0, 3'b100, 16'h0001, 4'd15, 0, 1, 0, 16'h0000, 16'h8000);
        addVec("sub01",   0, 1, 1, 0, 1, 0, 3'b100, 16'h8000, 4'd15, 1, 0, 1, 16'h0001, 16'h0000);
        addVec("slt_l1",  0, 1, 1, 0, 1, 1, 3'b101, 16'h00F0, 4'd3,  1, 0, 1, 16'h001E, 16'h0780);
        addVec("slt_l0",  1, 1, 1, 0, 1, 0, 3'b101, 16'h0F0F, 4'd12, 0, 1, 0, 16'h0000, 16'hF000);
        addVec("shl_op",  1, 1, 1, 0, 0, 1, 3'b001, 16'h0001, 4'd1,  0, 0, 1, 16'h0000, 16'h0002);
        addVec("shr_op",  1, 1, 0, 0, 0, 1, 3'b110, 16'h8000, 4'd1,  0, 0, 0, 16'h4000, 16'h0000);
        addVec("and_ainv",0, 1, 0, 1, 0, 0, 3'b000, 16'hC003, 4'd2,  1, 0, 0, 16'h3000, 16'h000C);
        addVec("or00",    0, 0, 0, 0, 0, 0, 3'b010, 16'h0000, 4'd7,  0, 0, 0, 16'h0000, 16'h0000);

        // Reset state while reset is held.
        #12;
        checkAll("reset_init", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        @(negedge clk);
        reset = 1'b0;
        en    = 1'b1;

        // Table-driven vectors: each result is visible #1 after the next edge.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkAll(vecs[i].name, vecs[i].exp_result, vecs[i].exp_cout,
                     vecs[i].exp_set, vecs[i].exp_r, vecs[i].exp_l);
        end

        // One-cycle latency: load ADD 1+1+1 with a shift, observe old values
        // before the edge and new values after it.
        @(negedge clk);
        a = 1'b1; b = 1'b1; cin = 1'b1; ainvert = 1'b0; bnegate = 1'b0;
        op = 3'b100; number = 16'h00FF; range = 4'd4;
        #1;
        checkAll("latency_pre", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        checkAll("latency_post", 1'b1, 1'b1, 1'b1, 16'h000F, 16'h0FF0);

        // Enable low: change every input, outputs must hold for two edges.
        @(negedge clk);
        en = 1'b0;
        a = 1'b0; b = 1'b0; cin = 1'b0; op = 3'b000;
        number = 16'hFFFF; range = 4'd0;
        @(posedge clk);
        #1;
        checkAll("hold1", 1'b1, 1'b1, 1'b1, 16'h000F, 16'h0FF0);
        @(posedge clk);
        #1;
        checkAll("hold2", 1'b1, 1'b1, 1'b1, 16'h000F, 16'h0FF0);

        // Asynchronous reset mid-cycle with nonzero outputs and a pending
        // enabled update: outputs clear at once, before any clock edge.
        @(negedge clk);
        en = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checkAll("async_reset", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        checkAll("reset_over_edge", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Release reset with en low: outputs stay cleared.
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
        @(posedge clk);
        #1;
        checkAll("release_en0", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Re-enable: FFFF with range 0 passes through; AND 0&0 gives zeros.
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        checkAll("reenable", 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
